// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the integer datapath: ALU function codes that
// touch the HI/LO pair, the multiplier control-state encoding and the
// default datapath width.
//
// Contents:
//    WIDTH    default operand width (32)
//    F_MULTU  function code that starts an unsigned multiply
//    F_HI     function code for mfhi (reads HI through the result mux)
//    F_LO     function code for mflo (reads LO through the result mux)
//    state_e  multiplier control states IDLE / RUN / DONE

package cpu_pkg;

   localparam int WIDTH = 32;

   localparam logic [5:0] F_MULTU = 6'd25;
   localparam logic [5:0] F_HI    = 6'd16;
   localparam logic [5:0] F_LO    = 6'd18;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mul_step.sv
// mul_step
// One iteration of a shift-add unsigned multiply. The accumulator holds
// the partial product in its upper W+1 bits and the not-yet-consumed
// multiplier bits in its lower W bits. When the current multiplier bit
// (acc_in[0]) is set, the multiplicand is added into the upper half; the
// whole accumulator is then shifted right by one.
//
// Ports:
//    acc_in   [2W:0]  accumulator before this iteration
//    mcand    [W-1:0] multiplicand
//    acc_out  [2W:0]  accumulator after the conditional add and shift

module mul_step #(
   parameter int W = 32
) (
   input  logic [2*W:0] acc_in,
   input  logic [W-1:0] mcand,
   output logic [2*W:0] acc_out
);

   logic [W:0] upper_sum;
   logic [W:0] upper_next;

   // The add is W+1 bits wide so the carry out of the W-bit add lands in
   // acc[2W]; the following shift moves it into the product's top bit.
   always_comb begin
      upper_sum  = acc_in[2*W:W] + {1'b0, mcand};
      upper_next = acc_in[0] ? upper_sum : acc_in[2*W:W];
      acc_out    = {upper_next, acc_in[W-1:0]} >> 1;
   end

endmodule

// File: rtl/multu_unit.sv
// multu_unit
// Sequential unsigned multiplier that owns the HI/LO register pair.
// An accepted multu runs 32 shift-add iterations (one per cycle) while
// holding the pipeline with busy, then commits the 2W-bit product to
// HI/LO and pulses done. HI/LO keep the previous product until then.
//
// Ports:
//    clk     clock, all state updates on the rising edge
//    rst_n   asynchronous active-low reset
//    start   an operation is offered this cycle
//    funct   function code, qualified by start
//    op_a    multiplicand (rs), sampled on acceptance
//    op_b    multiplier (rt), sampled on acceptance
//    flush   synchronous cancel of a pending or in-flight multiply
//    busy    multiply in progress, pipeline must stall
//    done    one-cycle pulse, HI/LO were updated at this edge
//    hi      upper half of the last committed product
//    lo      lower half of the last committed product

module multu_unit #(
   parameter int          WIDTH   = cpu_pkg::WIDTH,
   parameter logic [5:0]  F_MULTU = cpu_pkg::F_MULTU
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   import cpu_pkg::*;

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [2*WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic [2*WIDTH:0]   acc_step;
   logic               accept;

   mul_step #(
      .W (WIDTH)
   ) u_step (
      .acc_in  (acc_q),
      .mcand   (mcand_q),
      .acc_out (acc_step)
   );

   // A new request is only taken when no multiply is running; a start
   // during RUN is dropped without sampling the operands.
   assign accept = start && (funct == F_MULTU) && !flush && (state_q != RUN);

   // Control FSM, iteration counter and HI/LO commit. Flush beats both a
   // new request and the completing iteration, so a flushed multiply never
   // touches HI/LO.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept) begin
               mcand_d = op_a;
               acc_d   = {{(WIDTH+1){1'b0}}, op_b};
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               acc_d = acc_step;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_ITER) begin
                  hi_d    = acc_step[2*WIDTH-1:WIDTH];
                  lo_d    = acc_step[WIDTH-1:0];
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: doc/multu_unit.md
# multu_unit

Sequential 32-bit unsigned multiplier that executes the `multu` instructions issued by ALU control and owns the HI/LO register pair. It runs a 32-iteration shift-add multiply. While running it holds the pipeline with `busy`, and on completion it pulses `done` and commits the 64-bit product to HI/LO. `mfhi` and `mflo` read the `hi` and `lo` outputs through the ALU result mux.

## Interface
Parameters:
- `WIDTH`, 32: operand width; the product is 2·WIDTH.
- `F_MULTU`, 6'd25: function code that starts a multiply.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `start` in 1: an operation is offered this cycle.
- `funct` in 6: function code, qualified by `start`.
- `op_a` in WIDTH: multiplicand (rs), sampled on acceptance.
- `op_b` in WIDTH: multiplier (rt), sampled on acceptance.
- `flush` in 1: synchronous cancel of an in-flight multiply.
- `busy` out 1: multiply in progress; the pipeline must stall.
- `done` out 1: one-cycle pulse; HI/LO were updated at this edge.
- `hi` out WIDTH: HI register, upper half of the last committed product.
- `lo` out WIDTH: LO register, lower half of the last committed product.

## Operation
- States: IDLE, RUN, DONE.
- Acceptance:
  - A request is accepted when `start && funct == F_MULTU && !flush` and the state is IDLE or DONE.
  - On acceptance: mcand ← `op_a`; acc ← {WIDTH+1 zeros, `op_b`}; cnt ← 0; state → RUN.
  - `start` with any other `funct` is ignored.
  - `start` while in RUN is ignored and the operands are not sampled.
- RUN iteration, once per cycle:
  - If acc[0] = 1, then acc[2W:W] ← acc[2W:W] + {0, mcand}, computed as a (W+1)-bit sum so the carry is kept.
  - Then acc ← acc >> 1, logical shift.
  - cnt ← cnt + 1.
  - cnt is ⌈log2 W⌉+1 bits wide and never wraps within one operation.
- Completion: on the iteration where cnt reaches W−1:
  - {`hi`, `lo`} ← post-shift acc[2W−1:0];
  - `done` ← 1;
  - state → DONE.
- DONE lasts one cycle.
  - It goes to IDLE, or straight back to RUN if a new request is accepted.
  - `done` clears on the following edge.
- `hi`/`lo` change only at completion. They hold the previous product throughout RUN, so `mfhi`/`mflo` issued before a stall resolves read the old value.
- Flush:
  - `flush` in RUN returns to IDLE; `hi`/`lo` are unchanged and `done` stays 0.
  - `flush` in the same cycle as `start` wins, and the request is dropped.
  - `flush` on the completing cycle also wins: no commit, no `done`.
- `busy` is (state == RUN).
- Reset, asynchronous at any time including mid-RUN:
  - state = IDLE; cnt = 0; acc = 0; mcand = 0;
  - `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0.

## Timing
- Request accepted at edge E0.
  - `busy` is high from E0 to E32.
  - Iterations execute at E1…E32.
  - `hi`/`lo` and `done` update at E32; `done` is high for the single cycle E32–E33.
- Latency: 32 cycles from acceptance to the result being visible. Throughput is one multiply per 32 cycles when back-to-back.
- `busy` falls at the same edge that `done` rises. The stall releases in the cycle in which the new HI/LO are readable.
- No combinational path from `start`, `funct` or the operands to any output. All outputs are registered.

## Structure
- Shared package `cpu_pkg`:
  - function-code constants (F_MULTU = 25, F_HI = 16, F_LO = 18);
  - the state enum {IDLE, RUN, DONE};
  - the WIDTH default.
- Sub-module `mul_step`: combinational single iteration, (acc, mcand) → next acc, i.e. the conditional (W+1)-bit add plus the shift. It is instantiated once.
- The control FSM, counter, and HI/LO registers live in `multu_unit`.

## Test plan
- `op_a` = 3, `op_b` = 5, accepted at E0 → `busy` is high for 32 cycles; at E32 `done` = 1, `hi` = 0, `lo` = 15; `done` is 0 at E33.
- `op_a` = `op_b` = 0xFFFFFFFF → `hi` = 0xFFFFFFFE, `lo` = 0x00000001. This checks carry propagation through the 33-bit add.
- A second `start` with operands 7 and 7 at E10 of a run of 2×9 → ignored; the result is `lo` = 18; no second `done`.
- `start` with `funct` = 32 while IDLE → `busy` stays 0, no `done`, `hi`/`lo` unchanged. `start` in the DONE cycle with 4×4 → `busy` is high next cycle, then `lo` = 16 thirty-two cycles later.
- Previous product 15 committed, then `flush` at E20 of 6×6 → IDLE, `busy` = 0, `lo` stays 15, no `done`.
- `rst_n` low at E15 of 0x10000×0x10000 → `busy`, `done`, `hi`, `lo` = 0 immediately, without waiting for a clock edge; after release, a new 2×3 gives `lo` = 6 at the expected edge.
